// File: rtl/upper_imm_decode_pipe.sv
// Purpose: decode RV32I/RV64I U-type (LUI/AUIPC) into rd, imm, ALU code and result.
// Latency: 1 cycle; decoded entry visible the cycle after it is accepted.
// Backpressure: two-entry elastic buffer; registered in_ready drops while both entries are full.

`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef LUI
`define LUI 5'b01101
`endif
`ifndef AUIPC
`define AUIPC 5'b01110
`endif

module upper_imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_alu_control,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] result;
    logic [4:0]      alu;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_ENTRY = '{rd: 5'd0, imm: '0, result: '0, alu: `ALU_NOP, illegal: 1'b0};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  entry_t          r_head;
  entry_t          r_skid;
  entry_t          w_dec;
  logic [XLEN-1:0] w_imm;
  logic            w_acc;
  logic            w_pop;
  logic            w_load_head_in;
  logic            w_load_head_skid;
  logic            w_load_skid;
  logic [CNT_W-1:0] r_count;

  // The 20-bit upper immediate is sign-extended from instruction bit 31 up to XLEN.
  assign w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));

  // Decode the offered instruction; unknown opcodes keep rd but zero the data fields.
  always_comb begin
    w_dec         = RST_ENTRY;
    w_dec.rd      = in_instr[11:7];
    w_dec.illegal = 1'b1;
    case (in_instr[6:0])
      OPC_LUI: begin
        w_dec.imm     = w_imm;
        w_dec.result  = w_imm;
        w_dec.alu     = `LUI;
        w_dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        w_dec.imm     = w_imm;
        w_dec.result  = in_pc + w_imm;  // wraps modulo 2^XLEN
        w_dec.alu     = `AUIPC;
        w_dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // in_ready is gated by rst_n so nothing is taken while reset is held,
  // yet it is already high in the first cycle after release.
  assign in_ready  = r_in_ready & rst_n;
  assign out_valid = (r_state != ST_EMPTY);
  assign w_acc     = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  // Buffer occupancy next-state and entry load selects; flush wins over everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State register and registered ready (low exactly when the buffer will be full).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Head and skid entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= RST_ENTRY;
      r_skid <= RST_ENTRY;
    end else begin
      if (w_load_head_in) begin
        r_head <= w_dec;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  // Saturating count of accepted instructions; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_acc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_rd          = r_head.rd;
  assign out_imm         = r_head.imm;
  assign out_result      = r_head.result;
  assign out_alu_control = r_head.alu;
  assign out_illegal     = r_head.illegal;
  assign decode_count    = r_count;

endmodule

// File: tb/tb_upper_imm_decode_pipe.sv
// Directed bench for upper_imm_decode_pipe at XLEN=32 (CNT_W=16) and XLEN=64 (CNT_W=2).
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif
`ifndef LUI
`define LUI 5'b01101
`endif
`ifndef AUIPC
`define AUIPC 5'b01110
`endif

module tb_upper_imm_decode_pipe;

  logic        clk;
  logic        rst_n;

  // XLEN=32 instance
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_instr, a_pc, a_imm, a_result;
  logic [4:0]  a_rd, a_alu;
  logic [15:0] a_count;

  // XLEN=64 instance with a tiny counter
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm, b_result;
  logic [4:0]  b_rd, b_alu;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  upper_imm_decode_pipe #(.XLEN(32), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_instr), .in_pc(a_pc), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_rd(a_rd), .out_imm(a_imm), .out_result(a_result),
    .out_alu_control(a_alu), .out_illegal(a_illegal), .decode_count(a_count)
  );

  upper_imm_decode_pipe #(.XLEN(64), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_instr), .in_pc(b_pc), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_rd(b_rd), .out_imm(b_imm), .out_result(b_result),
    .out_alu_control(b_alu), .out_illegal(b_illegal), .decode_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_instr = '0; a_pc = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_instr = '0; b_pc = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    step();
    step();

    // Values while reset is held
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_result", a_result, 0);
    chk("rst_alu", a_alu, `ALU_NOP);
    chk("rst_illegal", a_illegal, 0);
    chk("rst_count", a_count, 0);

    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", a_in_ready, 1);

    // LUI x5,0x12345
    a_in_valid = 1'b1; a_instr = 32'h123452B7; a_pc = 32'h0000_0000;
    step();
    a_in_valid = 1'b0;
    chk("lui_valid", a_out_valid, 1);
    chk("lui_rd", a_rd, 5);
    chk("lui_imm", a_imm, 32'h12345000);
    chk("lui_result", a_result, 32'h12345000);
    chk("lui_alu", a_alu, `LUI);
    chk("lui_illegal", a_illegal, 0);
    chk("lui_count", a_count, 1);

    // AUIPC x10,1 at 0x80000000, then AUIPC x1,1 at 0xFFFFF000 back-to-back (wraps)
    a_in_valid = 1'b1; a_instr = 32'h00001517; a_pc = 32'h8000_0000;
    step();
    chk("auipc_rd", a_rd, 10);
    chk("auipc_result", a_result, 32'h80001000);
    chk("auipc_imm", a_imm, 32'h00001000);
    chk("auipc_alu", a_alu, `AUIPC);
    a_instr = 32'h00001097; a_pc = 32'hFFFF_F000;
    step();
    a_in_valid = 1'b0;
    chk("wrap_valid", a_out_valid, 1);
    chk("wrap_rd", a_rd, 1);
    chk("wrap_result", a_result, 32'h00000000);
    chk("wrap_count", a_count, 3);
    step();
    chk("drain_valid", a_out_valid, 0);

    // Illegal opcode (addi x0,x0,0)
    a_in_valid = 1'b1; a_instr = 32'h00000013; a_pc = 32'h0000_1000;
    step();
    a_in_valid = 1'b0;
    chk("ill_valid", a_out_valid, 1);
    chk("ill_alu", a_alu, `ALU_NOP);
    chk("ill_flag", a_illegal, 1);
    chk("ill_imm", a_imm, 0);
    chk("ill_result", a_result, 0);
    chk("ill_count", a_count, 4);
    step();

    // Backpressure: three offers with out_ready low, only two taken
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_instr = 32'h000010B7;
    step();
    chk("bp1_in_ready", a_in_ready, 1);
    a_instr = 32'h00002137;
    step();
    chk("bp2_in_ready", a_in_ready, 0);
    chk("bp2_head_rd", a_rd, 1);
    a_instr = 32'h000031B7;
    step();
    chk("bp3_in_ready", a_in_ready, 0);
    chk("bp3_count", a_count, 6);
    chk("bp3_head_stable", a_rd, 1);
    chk("bp3_imm_stable", a_imm, 32'h00001000);
    a_out_ready = 1'b1;
    step();
    chk("pop1_rd", a_rd, 2);
    chk("pop1_in_ready", a_in_ready, 1);
    chk("pop1_count", a_count, 6);
    step();
    a_in_valid = 1'b0;
    chk("pop2_rd", a_rd, 3);
    chk("pop2_imm", a_imm, 32'h00003000);
    chk("pop2_count", a_count, 7);
    step();
    chk("pop3_valid", a_out_valid, 0);

    // Flush while full and offering
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_instr = 32'h000010B7;
    step();
    a_instr = 32'h00002137;
    step();
    chk("fl2_count", a_count, 9);
    a_instr = 32'h000031B7; a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl2_valid", a_out_valid, 0);
    chk("fl2_in_ready", a_in_ready, 1);
    chk("fl2_count_after", a_count, 9);

    // Flush with one entry held while an offer meets in_ready=1
    a_in_valid = 1'b1; a_instr = 32'h000010B7;
    step();
    a_instr = 32'h000031B7; a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl1_valid", a_out_valid, 0);
    chk("fl1_count", a_count, 10);
    step();
    chk("fl1_never_out", a_out_valid, 0);

    // Reset with two entries held
    a_in_valid = 1'b1; a_instr = 32'h000010B7;
    step();
    a_instr = 32'h00002137;
    step();
    a_in_valid = 1'b0;
    chk("pre_rst_count", a_count, 12);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_in_ready", a_in_ready, 0);
    chk("mid_rst_rd", a_rd, 0);
    chk("mid_rst_imm", a_imm, 0);
    chk("mid_rst_alu", a_alu, `ALU_NOP);
    chk("mid_rst_count", a_count, 0);
    rst_n = 1'b1;
    a_out_ready = 1'b1;

    // XLEN=64: sign extension, AUIPC carry across bit 32, counter saturation
    b_in_valid = 1'b1; b_instr = 32'h800000B7; b_pc = 64'h0;
    step();
    chk("x64_lui_imm", b_imm, 64'hFFFFFFFF80000000);
    chk("x64_lui_result", b_result, 64'hFFFFFFFF80000000);
    chk("x64_lui_count", b_count, 1);
    b_instr = 32'h80000097; b_pc = 64'h0000_0001_0000_0000;
    step();
    chk("x64_auipc_result", b_result, 64'h0000000080000000);
    chk("x64_auipc_alu", b_alu, `AUIPC);
    b_instr = 32'h800000B7;
    step();
    chk("x64_sat3", b_count, 3);
    step();
    b_in_valid = 1'b0;
    chk("x64_sat_hold", b_count, 3);
    chk("x64_valid", b_out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
